mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 177 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit for the MEM stage. It issues one bus access at a time and
// stalls the front of the pipeline until the bus acknowledges or times out.
// Load data is aligned and sign/zero-extended into the MEM/WB registers.
// Store data is lane-replicated and given byte enables.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        rmem_i,
  input  logic        wmem_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] m_addr_i,
  input  logic [31:0] d_t_mem_i,
  input  logic [31:0] alu_out_i,
  input  logic        wreg_i,
  input  logic [4:0]  wr_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic        wb_wreg_o,
  output logic [4:0]  wb_wr_o,
  output logic [31:0] wb_data_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state_q;
  logic [31:0] cnt_q;
  logic [31:0] addr_q;
  logic [2:0]  f3_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        wreg_q;
  logic [4:0]  wr_q;
  logic        wb_wreg_q;
  logic [4:0]  wb_wr_q;
  logic [31:0] wb_data_q;
  logic        misalign_q;
  logic        bus_err_q;

  logic        mem_op;
  logic        is_byte;
  logic        is_half;
  logic        misalign;
  logic        aligned_op;
  logic        timeout;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;
  logic [31:0] load_d;

  // Decode the EX/MEM request: size, alignment and store lane encoding.
  always_comb begin
    mem_op     = rmem_i | wmem_i;
    is_byte    = (funct3_i[1:0] == 2'b00);
    is_half    = (funct3_i[1:0] == 2'b01);
    misalign   = mem_op & ((is_half & m_addr_i[0]) |
                           (~is_byte & ~is_half & (m_addr_i[1:0] != 2'b00)));
    aligned_op = mem_op & ~misalign;
    be_d       = 4'b1111;
    wdata_d    = d_t_mem_i;
    if (wmem_i) begin
      if (is_byte) begin
        be_d    = 4'b0001 << m_addr_i[1:0];
        wdata_d = {4{d_t_mem_i[7:0]}};
      end else if (is_half) begin
        be_d    = m_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{d_t_mem_i[15:0]}};
      end
    end
  end

  // Format the returned read word using the latched address and funct3.
  always_comb begin
    rbyte = mem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
    rhalf = mem_rdata_i[{addr_q[1], 4'b0000} +: 16];
    case (f3_q)
      3'b000:  load_d = {{24{rbyte[7]}}, rbyte};
      3'b100:  load_d = {24'h0, rbyte};
      3'b001:  load_d = {{16{rhalf[15]}}, rhalf};
      3'b101:  load_d = {16'h0, rhalf};
      default: load_d = mem_rdata_i;
    endcase
  end

  // Bus and stall outputs; reset forces request and stall low immediately.
  always_comb begin
    timeout     = (cnt_q == 32'(TIMEOUT - 1));
    mem_req_o   = clrn & (state_q == BUSY);
    stall_o     = clrn & (((state_q == IDLE) & aligned_op) |
                          ((state_q == BUSY) & ~mem_ack_i & ~timeout));
    mem_we_o    = we_q;
    mem_addr_o  = {addr_q[31:2], 2'b00};
    mem_be_o    = be_q;
    mem_wdata_o = wdata_q;
    wb_wreg_o   = wb_wreg_q;
    wb_wr_o     = wb_wr_q;
    wb_data_o   = wb_data_q;
    misalign_o  = misalign_q;
    bus_err_o   = bus_err_q;
  end

  // Access FSM: IDLE accepts requests or passes ALU results, BUSY waits for ack.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      f3_q       <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      wreg_q     <= 1'b0;
      wr_q       <= '0;
      wb_wreg_q  <= 1'b0;
      wb_wr_q    <= '0;
      wb_data_q  <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (aligned_op) begin
            state_q   <= BUSY;
            cnt_q     <= '0;
            addr_q    <= m_addr_i;
            f3_q      <= funct3_i;
            we_q      <= wmem_i;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            wreg_q    <= wreg_i;
            wr_q      <= wr_i;
            wb_wreg_q <= 1'b0;
          end else if (misalign) begin
            misalign_q <= 1'b1;
            wb_wreg_q  <= 1'b0;
          end else begin
            wb_data_q <= alu_out_i;
            wb_wr_q   <= wr_i;
            wb_wreg_q <= wreg_i & (wr_i != 5'd0);
          end
        end
        BUSY: begin
          if (mem_ack_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wb_data_q <= load_d;
            wb_wr_q   <= wr_q;
            wb_wreg_q <= ~we_q & wreg_q & (wr_q != 5'd0);
          end else if (timeout) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bus_err_q <= 1'b1;
            wb_wreg_q <= 1'b0;
          end else begin
            cnt_q     <= cnt_q + 32'd1;
            wb_wreg_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit (instantiated with TIMEOUT=4).
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        clrn;
  logic        rmem, wmem, wreg, ack;
  logic [2:0]  f3;
  logic [31:0] addr, dtm, alu, rdata;
  logic [4:0]  wr;
  logic        req, we, stall, wb_wreg, misal, berr;
  logic [31:0] maddr, wdata, wb_data;
  logic [3:0]  be;
  logic [4:0]  wb_wr;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .clrn(clrn), .rmem_i(rmem), .wmem_i(wmem), .funct3_i(f3),
    .m_addr_i(addr), .d_t_mem_i(dtm), .alu_out_i(alu), .wreg_i(wreg), .wr_i(wr),
    .mem_req_o(req), .mem_we_o(we), .mem_addr_o(maddr), .mem_be_o(be),
    .mem_wdata_o(wdata), .mem_ack_i(ack), .mem_rdata_i(rdata), .stall_o(stall),
    .wb_wreg_o(wb_wreg), .wb_wr_o(wb_wr), .wb_data_o(wb_data),
    .misalign_o(misal), .bus_err_o(berr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop();
    rmem = 0; wmem = 0; f3 = 0; addr = 0; dtm = 0; alu = 0;
    wreg = 0; wr = 0; ack = 0; rdata = 0;
  endtask

  task automatic test_reset();
    set_nop();
    clrn = 0; rmem = 1; f3 = 3'b010; addr = 32'h40;
    @(negedge clk);
    vectors++; if (req !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %0b want 0", req); end
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL rst_stall: got %0b want 0", stall); end
    step(); step();
    vectors++; if (wb_wreg !== 1'b0 || wb_wr !== 5'd0 || wb_data !== 32'h0)
      begin miscompares++; $display("FAIL rst_wb: got %0b/%0d/%h want 0/0/0", wb_wreg, wb_wr, wb_data); end
    vectors++; if (misal !== 1'b0 || berr !== 1'b0 || req !== 1'b0)
      begin miscompares++; $display("FAIL rst_flags: got mis=%0b err=%0b req=%0b want 0", misal, berr, req); end
    set_nop(); clrn = 1;
    step();
  endtask

  task automatic test_lb();
    set_nop(); rmem = 1; f3 = 3'b000; addr = 32'h103; wreg = 1; wr = 5;
    @(negedge clk);
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL lb_stall_c0: got %0b want 1", stall); end
    vectors++; if (req !== 1'b0) begin miscompares++; $display("FAIL lb_req_c0: got %0b want 0", req); end
    step();
    @(negedge clk);
    vectors++; if (req !== 1'b1 || stall !== 1'b1) begin miscompares++; $display("FAIL lb_busy1: got req=%0b stall=%0b want 1/1", req, stall); end
    vectors++; if (maddr !== 32'h100 || be !== 4'b1111 || we !== 1'b0)
      begin miscompares++; $display("FAIL lb_bus: got %h/%b/%0b want 00000100/1111/0", maddr, be, we); end
    step();
    ack = 1; rdata = 32'h80FF_1234;
    @(negedge clk);
    vectors++; if (stall !== 1'b0 || req !== 1'b1) begin miscompares++; $display("FAIL lb_ackcyc: got stall=%0b req=%0b want 0/1", stall, req); end
    step();
    set_nop();
    vectors++; if (wb_data !== 32'hFFFF_FF80) begin miscompares++; $display("FAIL lb_data: got %h want ffffff80", wb_data); end
    vectors++; if (wb_wreg !== 1'b1 || wb_wr !== 5'd5) begin miscompares++; $display("FAIL lb_wreg: got %0b/%0d want 1/5", wb_wreg, wb_wr); end
    vectors++; if (req !== 1'b0) begin miscompares++; $display("FAIL lb_req_after: got %0b want 0", req); end
    step();
  endtask

  task automatic test_store();
    // SH: inputs change during BUSY and must not disturb the bus fields.
    set_nop(); wmem = 1; f3 = 3'b001; addr = 32'h202; dtm = 32'h0000_ABCD; wreg = 1; wr = 3;
    @(negedge clk);
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL sh_stall: got %0b want 1", stall); end
    step();
    addr = 32'h0000_0F01; dtm = 32'h1111_2222; f3 = 3'b000;
    ack = 1;
    @(negedge clk);
    vectors++; if (be !== 4'b1100 || wdata !== 32'hABCD_ABCD || we !== 1'b1 || maddr !== 32'h200)
      begin miscompares++; $display("FAIL sh_bus: got be=%b wd=%h we=%0b a=%h want 1100/abcdabcd/1/00000200", be, wdata, we, maddr); end
    vectors++; if (req !== 1'b1 || stall !== 1'b0) begin miscompares++; $display("FAIL sh_ackcyc: got req=%0b stall=%0b want 1/0", req, stall); end
    step();
    set_nop();
    vectors++; if (wb_wreg !== 1'b0) begin miscompares++; $display("FAIL sh_wreg: got %0b want 0", wb_wreg); end
    step();
    // SB at byte 1.
    wmem = 1; f3 = 3'b000; addr = 32'h101; dtm = 32'h0012_3455;
    step();
    ack = 1;
    @(negedge clk);
    vectors++; if (be !== 4'b0010 || wdata !== 32'h5555_5555 || we !== 1'b1)
      begin miscompares++; $display("FAIL sb_bus: got be=%b wd=%h we=%0b want 0010/55555555/1", be, wdata, we); end
    step();
    set_nop();
    step();
  endtask

  task automatic test_misalign();
    set_nop(); rmem = 1; f3 = 3'b010; addr = 32'h006; wreg = 1; wr = 4; alu = 32'h99;
    @(negedge clk);
    vectors++; if (stall !== 1'b0 || req !== 1'b0) begin miscompares++; $display("FAIL mis_c0: got stall=%0b req=%0b want 0/0", stall, req); end
    step();
    set_nop();
    vectors++; if (misal !== 1'b1 || wb_wreg !== 1'b0 || req !== 1'b0)
      begin miscompares++; $display("FAIL mis_pulse: got mis=%0b wreg=%0b req=%0b want 1/0/0", misal, wb_wreg, req); end
    step();
    vectors++; if (misal !== 1'b0) begin miscompares++; $display("FAIL mis_once: got %0b want 0", misal); end
    // Odd halfword is misaligned too.
    wmem = 1; f3 = 3'b001; addr = 32'h011;
    @(negedge clk);
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL mis_sh_stall: got %0b want 0", stall); end
    step();
    set_nop();
    vectors++; if (misal !== 1'b1 || req !== 1'b0) begin miscompares++; $display("FAIL mis_sh: got mis=%0b req=%0b want 1/0", misal, req); end
    step();
  endtask

  task automatic test_timeout();
    int unsigned reqcnt;
    reqcnt = 0;
    set_nop(); rmem = 1; f3 = 3'b010; addr = 32'h40; wreg = 1; wr = 2;
    @(negedge clk);
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL to_stall_c0: got %0b want 1", stall); end
    step();
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (req === 1'b1) reqcnt++;
      vectors++;
      if (stall !== (i < 4)) begin miscompares++; $display("FAIL to_stall_b%0d: got %0b want %0b", i, stall, (i < 4)); end
      step();
    end
    set_nop(); ack = 1; rdata = 32'h1234_5678;
    vectors++; if (berr !== 1'b1 || wb_wreg !== 1'b0) begin miscompares++; $display("FAIL to_err: got err=%0b wreg=%0b want 1/0", berr, wb_wreg); end
    @(negedge clk);
    if (req === 1'b1) reqcnt++;
    step();
    ack = 0;
    vectors++; if (reqcnt != 4) begin miscompares++; $display("FAIL to_reqcnt: got %0d want 4", reqcnt); end
    vectors++; if (berr !== 1'b0 || wb_wreg !== 1'b0) begin miscompares++; $display("FAIL to_late_ack: got err=%0b wreg=%0b want 0/0", berr, wb_wreg); end
    step();
  endtask

  task automatic test_reset_busy();
    set_nop(); rmem = 1; f3 = 3'b010; addr = 32'h80; wreg = 1; wr = 6; alu = 32'h55;
    step();
    step();
    clrn = 0;
    @(negedge clk);
    vectors++; if (req !== 1'b0 || stall !== 1'b0) begin miscompares++; $display("FAIL rb_comb: got req=%0b stall=%0b want 0/0", req, stall); end
    step();
    clrn = 1; set_nop(); ack = 1; rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    vectors++; if (req !== 1'b0 || wb_wreg !== 1'b0 || wb_data !== 32'h0 || berr !== 1'b0)
      begin miscompares++; $display("FAIL rb_after: got req=%0b wreg=%0b data=%h err=%0b want 0/0/0/0", req, wb_wreg, wb_data, berr); end
    step();
    vectors++; if (wb_wreg !== 1'b0 || wb_data !== 32'h0 || berr !== 1'b0)
      begin miscompares++; $display("FAIL rb_ack_ignored: got wreg=%0b data=%h err=%0b want 0/0/0", wb_wreg, wb_data, berr); end
    set_nop(); alu = 32'h1234; wreg = 1; wr = 7;
    step();
    set_nop();
    vectors++; if (wb_data !== 32'h1234 || wb_wreg !== 1'b1 || wb_wr !== 5'd7)
      begin miscompares++; $display("FAIL rb_alu: got %h/%0b/%0d want 00001234/1/7", wb_data, wb_wreg, wb_wr); end
    step();
  endtask

  task automatic test_back_to_back();
    set_nop(); rmem = 1; f3 = 3'b101; addr = 32'h10; wreg = 1; wr = 8;
    step();
    ack = 1; rdata = 32'h1234_F00D;
    step();
    set_nop(); alu = 32'd7; wreg = 1; wr = 9;
    vectors++; if (wb_data !== 32'h0000_F00D || wb_wreg !== 1'b1 || wb_wr !== 5'd8)
      begin miscompares++; $display("FAIL b2b_lhu: got %h/%0b/%0d want 0000f00d/1/8", wb_data, wb_wreg, wb_wr); end
    @(negedge clk);
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL b2b_stall: got %0b want 0", stall); end
    step();
    set_nop();
    vectors++; if (wb_data !== 32'd7 || wb_wreg !== 1'b1 || wb_wr !== 5'd9)
      begin miscompares++; $display("FAIL b2b_add: got %h/%0b/%0d want 00000007/1/9", wb_data, wb_wreg, wb_wr); end
    // Writes to x0 are suppressed.
    alu = 32'hAA; wreg = 1; wr = 0;
    step();
    set_nop();
    vectors++; if (wb_wreg !== 1'b0) begin miscompares++; $display("FAIL x0_wreg: got %0b want 0", wb_wreg); end
    step();
  endtask

  task automatic test_load_formats();
    logic [2:0]  tf3 [6];
    logic [31:0] tad [6];
    logic [31:0] texp [6];
    tf3[0] = 3'b000; tad[0] = 32'h101; texp[0] = 32'h0000_0012;
    tf3[1] = 3'b100; tad[1] = 32'h103; texp[1] = 32'h0000_0080;
    tf3[2] = 3'b001; tad[2] = 32'h112; texp[2] = 32'hFFFF_8001;
    tf3[3] = 3'b101; tad[3] = 32'h112; texp[3] = 32'h0000_8001;
    tf3[4] = 3'b010; tad[4] = 32'h114; texp[4] = 32'h8001_1234;
    tf3[5] = 3'b011; tad[5] = 32'h118; texp[5] = 32'h8001_1234;
    for (int i = 0; i < 6; i++) begin
      set_nop(); rmem = 1; f3 = tf3[i]; addr = tad[i]; wreg = 1; wr = 5'd10;
      step();
      ack = 1; rdata = 32'h8001_1234;
      step();
      set_nop();
      vectors++;
      if (wb_data !== texp[i] || wb_wreg !== 1'b1)
        begin miscompares++; $display("FAIL fmt_%0d: got %h/%0b want %h/1", i, wb_data, wb_wreg, texp[i]); end
    end
    step();
  endtask

  initial begin
    set_nop();
    clrn = 0;
    test_reset();
    test_lb();
    test_store();
    test_misalign();
    test_timeout();
    test_reset_busy();
    test_back_to_back();
    test_load_formats();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
